// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
//   state_e         : controller phases (IDLE, LOW, HIGH, DONE)
//   *_DEF           : default parameter values
//   HALF_LO/HALF_HI : half-word select bit appended to the word index
//   cnt_width()     : wait-counter width for a given WAIT_CYCLES
package mem_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  localparam int DATA_BASE_DEF   = 1024;
  localparam int SRAM_ADDR_W_DEF = 18;
  localparam int WAIT_CYCLES_DEF = 2;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Keeps the counter at least one bit wide when WAIT_CYCLES == 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_sram_ctrl_if.sv
// MEM-stage request bus between the pipeline and the SRAM controller.
//   rd_en/wr_en : load/store request levels, held until ready
//   address     : byte address, write_data : store data
//   read_data   : loaded word, ready : 0 stalls the pipeline
// master = pipeline side, slave = controller side.
interface mem_sram_ctrl_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output rd_en, wr_en, address, write_data,
                  input  read_data, ready);
  modport slave  (input  rd_en, wr_en, address, write_data,
                  output read_data, ready);
endinterface

// File: rtl/mem_wait_counter.sv
// Per-phase wait counter for the SRAM controller.
//   clk, rst : clock, synchronous active-high reset (clears the count)
//   load     : phase entry, reload WAIT_CYCLES-1
//   last     : count is 0, i.e. this is the final cycle of the phase
module mem_wait_counter
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);
  localparam int CW = cnt_width(WAIT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = CW'(WAIT_CYCLES - 1);
    else if (cnt_q != '0)  cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last = (cnt_q == '0);
endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit load/store into two
// sequential 16-bit accesses (low half, then high half) on an async SRAM.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : pipeline request bus; ready=0 stalls the pipeline
//   sram_addr    : half-word address {word index, half select}
//   sram_dq_out  : write data to pad, sram_dq_oe : pad drive enable
//   sram_dq_in   : read data from pad, sram_we_n : write strobe (active-low)
// The pad tri-state lives above this block.
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int SRAM_ADDR_W = SRAM_ADDR_W_DEF,
  parameter int DATA_BASE   = DATA_BASE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_sram_ctrl_if.slave         bus,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);
  localparam int IDX_W = SRAM_ADDR_W - 1;

  state_e                 state_q, state_d;
  logic                   wr_q, wr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [15:0]            wdata_hi_q, wdata_hi_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]            dqo_q, dqo_d;
  logic                   oe_q, oe_d;
  logic                   wen_q, wen_d;
  logic                   cnt_load, cnt_last, req;

  // Word index relative to DATA_BASE; upper bits wrap away silently.
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx_in;
  logic             unused_offset_bits;
  assign offset             = bus.address - 32'(DATA_BASE);
  assign idx_in             = offset[IDX_W+1:2];
  assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};

  assign req = bus.rd_en | bus.wr_en;

  mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .last (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    wdata_hi_d = wdata_hi_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    dqo_d      = dqo_q;
    oe_d       = oe_q;
    wen_d      = wen_q;
    cnt_load   = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        // Write wins when both requests are high.
        state_d    = LOW;
        wr_d       = bus.wr_en;
        idx_d      = idx_in;
        wdata_hi_d = bus.write_data[31:16];
        addr_d     = {idx_in, HALF_LO};
        dqo_d      = bus.write_data[15:0];
        oe_d       = bus.wr_en;
        wen_d      = ~bus.wr_en;
        cnt_load   = 1'b1;
      end
      LOW: if (cnt_last) begin
        state_d  = HIGH;
        addr_d   = {idx_q, HALF_HI};
        dqo_d    = wdata_hi_q;
        cnt_load = 1'b1;
        if (!wr_q) rdata_d[15:0] = sram_dq_in;
      end
      HIGH: if (cnt_last) begin
        state_d = DONE;
        oe_d    = 1'b0;
        wen_d   = 1'b1;
        if (!wr_q) rdata_d[31:16] = sram_dq_in;
      end
      // The pipeline advances on this edge, so a still-held request is
      // the one just served and must not restart.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_hi_q <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      dqo_q      <= '0;
      oe_q       <= 1'b0;
      wen_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      wdata_hi_q <= wdata_hi_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      dqo_q      <= dqo_d;
      oe_q       <= oe_d;
      wen_q      <= wen_d;
    end
  end

  assign bus.ready     = (state_q == IDLE) ? ~req : (state_q == DONE);
  assign bus.read_data = rdata_q;
  assign sram_addr     = addr_q;
  assign sram_dq_out   = dqo_q;
  assign sram_dq_oe    = oe_q;
  assign sram_we_n     = wen_q;
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: directed cases plus randomized loads/stores
// checked against a half-word reference memory and an async SRAM model
// that commits a write on the trailing end of the strobe.
module tb_mem_sram_ctrl;
  localparam int W    = 2;
  localparam int AW   = 18;
  localparam int BASE = 1024;
  localparam int HW   = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_sram_ctrl_if bus();
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_we_n;

  mem_sram_ctrl #(.WAIT_CYCLES(W), .SRAM_ADDR_W(AW), .DATA_BASE(BASE)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  // Async SRAM: write lands when we_n rises or the address moves, unless
  // the strobe was cut short by a controller reset.
  logic [15:0]   sram [0:HW-1];
  logic          last_we_n = 1'b1, last_rst = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [15:0]   last_dq   = '0;
  assign sram_dq_in = sram[sram_addr];
  initial begin
    for (int i = 0; i < HW; i++) sram[i] = 16'h0;
    sram[2] = 16'h1234;
    sram[3] = 16'h5678;
    forever begin
      @(negedge clk);
      if (!last_we_n && !last_rst && (sram_we_n || sram_addr != last_addr))
        sram[last_addr] = last_dq;
      last_we_n = sram_we_n;
      last_addr = sram_addr;
      last_dq   = sram_dq_out;
      last_rst  = rst;
    end
  end

  // Reference: plain half-word array plus the expected read_data word.
  bit [15:0]   ref_mem [0:HW-1];
  logic [31:0] exp_rd = 32'h0;
  int passed = 0, total = 0;

  function automatic int hw_lo(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'(BASE)) >> 2;
    return int'((w % (32'd1 << (AW - 1))) * 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ready"}, 32'(bus.ready), 32'd1);
    chk({tag, " oe"},    32'(sram_dq_oe), 32'd0);
    chk({tag, " we_n"},  32'(sram_we_n), 32'd1);
    chk({tag, " rdata"}, bus.read_data, exp_rd);
  endtask

  // Drive a request in the current cycle (cycle 0), check every cycle up
  // to DONE, then drop the request at the following edge.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input int drop_cyc);
    int lo, hi;
    bit half;
    lo = hw_lo(a);
    hi = lo + 1;
    bus.rd_en = rd; bus.wr_en = wr; bus.address = a; bus.write_data = d;
    #1;
    chk("stall c0", 32'(bus.ready), 32'd0);
    for (int c = 1; c <= 2 * W + 1; c++) begin
      @(posedge clk); #1;
      if (drop_cyc >= 0 && c == drop_cyc + 1) begin
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        bus.address = $urandom; bus.write_data = $urandom;
      end
      #1;
      if (c <= 2 * W) begin
        half = (c > W);
        chk($sformatf("stall c%0d", c), 32'(bus.ready), 32'd0);
        chk($sformatf("addr c%0d", c), 32'(sram_addr), 32'(half ? hi : lo));
        chk($sformatf("oe c%0d", c), 32'(sram_dq_oe), 32'(wr));
        chk($sformatf("we_n c%0d", c), 32'(sram_we_n), 32'(!wr));
        if (wr) chk($sformatf("dq c%0d", c), 32'(sram_dq_out),
                    32'(half ? d[31:16] : d[15:0]));
      end else begin
        if (wr) begin
          ref_mem[lo] = d[15:0];
          ref_mem[hi] = d[31:16];
        end else begin
          exp_rd = {ref_mem[hi], ref_mem[lo]};
        end
        chk("done ready", 32'(bus.ready), 32'd1);
        chk("done rdata", bus.read_data, exp_rd);
      end
    end
    @(posedge clk); #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] a, d;
    int lo;
    bit rd, wr;
    ref_mem[2] = 16'h1234;
    ref_mem[3] = 16'h5678;
    rst = 1'b1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = '0; bus.write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset addr", 32'(sram_addr), 32'd0);
    chk("reset dq",   32'(sram_dq_out), 32'd0);
    bus.rd_en = 1'b1; #1;
    chk("reset ready req", 32'(bus.ready), 32'd0);
    bus.rd_en = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Word write at the base, then read of the preloaded word at 1028.
    txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, -1);
    chk_idle("after write");
    txn(1'b1, 1'b0, 32'd1028, 32'h0, -1);
    chk("read 1028", bus.read_data, 32'h56781234);
    // Request held through DONE: the following cycles stay idle.
    chk_idle("held c+1");
    @(posedge clk); #1;
    chk_idle("held c+2");

    // Both enables: a write at half-words 4/5, read_data untouched.
    txn(1'b1, 1'b1, 32'd1032, 32'h0000FFFF, -1);
    chk("rw rdata kept", bus.read_data, 32'h56781234);
    txn(1'b1, 1'b0, 32'd1032, 32'h0, -1);
    chk("rw readback", bus.read_data, 32'h0000FFFF);

    // Back-to-back: next request issued in the cycle right after DONE.
    txn(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, -1);
    txn(1'b1, 1'b0, 32'd1040, 32'h0, -1);
    chk("b2b readback", bus.read_data, 32'hCAFEF00D);

    // Reset in the 2nd HIGH cycle of a write: only the low half lands.
    bus.wr_en = 1'b1; bus.address = 32'd1040; bus.write_data = 32'h11112222;
    for (int c = 1; c <= 2 * W; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.wr_en = 1'b0;
    #1;
    exp_rd = 32'h0;
    chk_idle("abort");
    chk("abort addr", 32'(sram_addr), 32'd0);
    lo = hw_lo(32'd1040);
    ref_mem[lo] = 16'h2222;
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 32'd1040, 32'h0, -1);
    chk("abort readback", bus.read_data, 32'hCAFE2222);

    // rd_en dropped after cycle 1: transaction still completes.
    txn(1'b1, 1'b0, 32'd1024, 32'h0, 1);
    chk("drop readback", bus.read_data, 32'hDEADBEEF);
    chk_idle("drop idle");

    // Randomized loads/stores, some far outside the window to wrap.
    for (int n = 0; n < 24; n++) begin
      wr = ($urandom_range(0, 1) == 1);
      rd = !wr || ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) a = $urandom;
      else a = 32'(BASE) + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      d = $urandom;
      txn(rd, wr, a, d, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
      if ($urandom_range(0, 1) == 1) begin
        chk_idle($sformatf("rand idle %0d", n));
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
